// File: rtl/decred_spi_pkg.sv
// decred_spi_pkg: shared state encoding and frame constants for the SPI register slave
package decred_spi_pkg;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_FETCH, DATA_RD, DATA_WR, SKIP} state_e;
  localparam logic [6:0] BROADCAST_ADDR = 7'h7F;
  localparam int RW_BIT = 0;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-flop pin synchronizer with rise/fall detect on the stable sample
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic SPI_CLK,
  input  logic RST,
  input  logic pin_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  // shift the pin through the chain and keep the previous stable sample for edge detect
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end
  // synchronizer and history registers
  always_ff @(posedge SPI_CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;
endmodule

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: oversampled SPI mode-0 slave driving a parallel register port; SPI_BROADCAST_EN adds write broadcast on dev 7'h7F
module spi_reg_slave
  import decred_spi_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  SPI_CLK,
  input  logic                  RST,
  input  logic                  sclk_in,
  input  logic                  csn_in,
  input  logic                  mosi_in,
  output logic                  miso_out,
  output logic                  miso_oe,
  input  logic [6:0]            dev_addr,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_strobe,
  output logic                  write_strobe,
  input  logic [DATA_WIDTH-1:0] data_in
);
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic csn_s, csn_rise, csn_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, tx_q, tx_d, byte_v;
  logic rw_q, rw_d, rd_q, rd_d, wr_q, wr_d, oe_q, oe_d, last, sel;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .SPI_CLK(SPI_CLK), .RST(RST), .pin_in(sclk_in), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_csn (
    .SPI_CLK(SPI_CLK), .RST(RST), .pin_in(csn_in), .level(csn_s), .rise(csn_rise), .fall(csn_fall));
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
    .SPI_CLK(SPI_CLK), .RST(RST), .pin_in(mosi_in), .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

  assign unused_sync = ^{sclk_lvl, csn_rise, mosi_rise, mosi_fall, shift_q[7]};
  assign byte_v = {shift_q[6:0], mosi_s};
  assign last = sclk_rise && cnt_q == 3'd7;

  // Broadcast only ever selects the chip for writes so shared-bus reads never collide
`ifdef SPI_BROADCAST_EN
  assign sel = (byte_v[7:1] == BROADCAST_ADDR) ? ~byte_v[RW_BIT] : byte_v[7:1] == dev_addr;
`else
  assign sel = byte_v[7:1] == dev_addr;
`endif

  // frame decode: bit counting, state transitions, strobes and MISO shifting
  always_comb begin
    state_d = state_q;
    cnt_d   = sclk_rise ? cnt_q + 3'd1 : cnt_q;
    shift_d = sclk_rise ? byte_v : shift_q;
    rw_d    = rw_q;
    addr_d  = wr_q ? addr_q + ADDR_WIDTH'(1) : addr_q;
    data_d  = data_q;
    tx_d    = tx_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    if (csn_s) begin
      state_d = IDLE;
      cnt_d   = '0;
      shift_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          shift_d = '0;
          state_d = csn_fall ? CMD : IDLE;
        end
        CMD: if (last) begin
          rw_d    = byte_v[RW_BIT];
          state_d = sel ? ADDR : SKIP;
        end
        ADDR: if (last) begin
          addr_d  = ADDR_WIDTH'(byte_v);
          rd_d    = rw_q;
          state_d = rw_q ? RD_FETCH : DATA_WR;
        end
        RD_FETCH: if (!rd_q) begin
          tx_d    = 8'(data_in);
          state_d = DATA_RD;
        end
        DATA_RD: begin
          if (sclk_fall && cnt_q != 3'd0) tx_d = {tx_q[6:0], 1'b0};
          if (last) begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            rd_d    = 1'b1;
            state_d = RD_FETCH;
          end
        end
        DATA_WR: if (last) begin
          data_d = DATA_WIDTH'(byte_v);
          wr_d   = 1'b1;
        end
        SKIP: state_d = SKIP;
        default: state_d = IDLE;
      endcase
    end
    oe_d = state_d == RD_FETCH || state_d == DATA_RD;
  end

  // state and datapath registers
  always_ff @(posedge SPI_CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      tx_q    <= '0;
      rw_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      oe_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      oe_q    <= oe_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign address      = addr_q;
  assign data_out     = data_q;
  assign read_strobe  = rd_q;
  assign write_strobe = wr_q;
  assign miso_oe      = oe_q;
  assign miso_out     = oe_q & tx_q[7];
endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: directed SPI frames against spi_reg_slave with a stub register bank
module tb_spi_reg_slave;
  import decred_spi_pkg::*;
  localparam int HALF = 60;
  logic SPI_CLK = 1'b0, RST = 1'b1, sclk_in = 1'b0, csn_in = 1'b1, mosi_in = 1'b0;
  logic miso_out, miso_oe, read_strobe, write_strobe;
  logic [6:0] dev_addr = 7'h05;
  logic [7:0] address, data_out;
  logic [7:0] data_in = 8'h00;
  int total = 0, bad = 0;
  int wr_cnt = 0, rd_cnt = 0, oe_cnt = 0, both_cnt = 0, viol_cnt = 0;
  logic [7:0] wr_addr [64];
  logic [7:0] wr_data [64];
  logic [7:0] rd_addr [64];
  int w0, r0, o0;
  logic [7:0] rx;

  spi_reg_slave dut (
    .SPI_CLK(SPI_CLK), .RST(RST), .sclk_in(sclk_in), .csn_in(csn_in), .mosi_in(mosi_in),
    .miso_out(miso_out), .miso_oe(miso_oe), .dev_addr(dev_addr), .address(address),
    .data_out(data_out), .read_strobe(read_strobe), .write_strobe(write_strobe), .data_in(data_in));

  always #5 SPI_CLK = ~SPI_CLK;

  function automatic logic [7:0] stub_rd(input logic [7:0] a);
    return a == 8'h05 ? 8'h11 : a == 8'h06 ? 8'h22 : a ^ 8'hA5;
  endfunction

  always @(posedge SPI_CLK) if (read_strobe) data_in <= stub_rd(address);

  always @(negedge SPI_CLK) begin
    if (write_strobe) begin
      wr_addr[wr_cnt % 64] <= address;
      wr_data[wr_cnt % 64] <= data_out;
      wr_cnt <= wr_cnt + 1;
    end
    if (read_strobe) begin
      rd_addr[rd_cnt % 64] <= address;
      rd_cnt <= rd_cnt + 1;
    end
    if (miso_oe) oe_cnt <= oe_cnt + 1;
    if (read_strobe && write_strobe) both_cnt <= both_cnt + 1;
    if (!miso_oe && miso_out) viol_cnt <= viol_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] v, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi_in = v[i];
      #HALF;
      sclk_in = 1'b1;
      r[i] = miso_out;
      #HALF;
      sclk_in = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] v);
    logic [7:0] r;
    spi_bits(v, 8, r);
  endtask

  task automatic frame_start;
    csn_in = 1'b0;
    #HALF;
  endtask

  task automatic frame_end;
    #HALF;
    csn_in = 1'b1;
    #(4 * HALF);
  endtask

  initial begin
    #52;
    check("rst_address", address, 8'h00);
    check("rst_data_out", data_out, 8'h00);
    check("rst_rd_strobe", read_strobe, 1'b0);
    check("rst_wr_strobe", write_strobe, 1'b0);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_miso_out", miso_out, 1'b0);
    check("rst_state", dut.state_q, IDLE);
    RST = 1'b0;
    #100;

    w0 = wr_cnt; o0 = oe_cnt;
    frame_start; send(8'h0A); send(8'h03); send(8'h11); frame_end;
    check("wr1_count", wr_cnt - w0, 1);
    check("wr1_addr", wr_addr[w0], 8'h03);
    check("wr1_data", wr_data[w0], 8'h11);
    check("wr1_no_oe", oe_cnt - o0, 0);

    w0 = wr_cnt;
    frame_start; send(8'h0A); send(8'hFE); send(8'h01); send(8'h02); send(8'h03); frame_end;
    check("wrap_count", wr_cnt - w0, 3);
    check("wrap_addr0", wr_addr[w0], 8'hFE);
    check("wrap_data0", wr_data[w0], 8'h01);
    check("wrap_addr1", wr_addr[w0 + 1], 8'hFF);
    check("wrap_data1", wr_data[w0 + 1], 8'h02);
    check("wrap_addr2", wr_addr[w0 + 2], 8'h00);
    check("wrap_data2", wr_data[w0 + 2], 8'h03);

    w0 = wr_cnt; r0 = rd_cnt; o0 = oe_cnt;
    frame_start; send(8'h0B); send(8'h05); spi_bits(8'h00, 8, rx);
    check("rd_miso_byte", rx, 8'h11);
    #(2 * HALF);
    check("rd_oe_during", miso_oe, 1'b1);
    frame_end;
    check("rd_count", rd_cnt - r0, 2);
    check("rd_addr0", rd_addr[r0], 8'h05);
    check("rd_addr1", rd_addr[r0 + 1], 8'h06);
    check("rd_no_write", wr_cnt - w0, 0);
    check("rd_oe_after", miso_oe, 1'b0);

    w0 = wr_cnt; r0 = rd_cnt; o0 = oe_cnt;
    frame_start; send(8'h0C); send(8'h03); send(8'h55); frame_end;
    frame_start; send(8'h0D); send(8'h05); send(8'h00); frame_end;
    check("other_dev_wr", wr_cnt - w0, 0);
    check("other_dev_rd", rd_cnt - r0, 0);
    check("other_dev_oe", oe_cnt - o0, 0);
    frame_start; send(8'h0A); send(8'h10); send(8'h77); frame_end;
    check("after_other_count", wr_cnt - w0, 1);
    check("after_other_addr", wr_addr[w0], 8'h10);
    check("after_other_data", wr_data[w0], 8'h77);

    w0 = wr_cnt;
    frame_start; send(8'h0A); send(8'h20); spi_bits(8'hFF, 4, rx); frame_end;
    check("partial_no_wr", wr_cnt - w0, 0);
    check("partial_state", dut.state_q, IDLE);
    frame_start; send(8'h0A); send(8'h21); send(8'h5A); frame_end;
    check("partial_next_addr", wr_addr[w0], 8'h21);
    check("partial_next_data", wr_data[w0], 8'h5A);

    w0 = wr_cnt;
    frame_start; spi_bits(8'h0A, 4, rx);
    RST = 1'b1;
    #30;
    check("midrst_address", address, 8'h00);
    check("midrst_data_out", data_out, 8'h00);
    check("midrst_wr_strobe", write_strobe, 1'b0);
    check("midrst_state", dut.state_q, IDLE);
    RST = 1'b0;
    #30;
    spi_bits(8'hA0, 4, rx); send(8'h40); send(8'h99); frame_end;
    check("midrst_ignored", wr_cnt - w0, 0);
    frame_start; send(8'h0A); send(8'h30); send(8'h99); frame_end;
    check("midrst_next_count", wr_cnt - w0, 1);
    check("midrst_next_addr", wr_addr[w0], 8'h30);
    check("midrst_next_data", wr_data[w0], 8'h99);

    w0 = wr_cnt; r0 = rd_cnt; o0 = oe_cnt;
    frame_start; send(8'hFE); send(8'h03); send(8'h01); frame_end;
`ifdef SPI_BROADCAST_EN
    check("bcast_wr_count", wr_cnt - w0, 1);
    check("bcast_wr_addr", wr_addr[w0], 8'h03);
    check("bcast_wr_data", wr_data[w0], 8'h01);
`else
    check("bcast_wr_count", wr_cnt - w0, 0);
`endif
    w0 = wr_cnt;
    frame_start; send(8'hFF); send(8'h07); send(8'h00); frame_end;
    check("bcast_rd_count", rd_cnt - r0, 0);
    check("bcast_rd_oe", oe_cnt - o0, 0);
    check("bcast_rd_no_wr", wr_cnt - w0, 0);

    check("never_both_strobes", both_cnt, 0);
    check("miso_quiet_without_oe", viol_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
